// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART rx/tx blocks:
//               FSM state encoding, frame levels, timer width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Receiver/transmitter FSM states (PARITY only used with parity builds)
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width able to hold 0..clks-1, never narrower than one bit
    function automatic int timer_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module      : uart_bit_timer
// Description : Per-bit tick counter (0..CLKS_PER_BIT-1) with synchronous
//               restart and half-period / full-period compare flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic CLR,
    input  logic restart,
    output logic half_hit,
    output logic full_hit
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int TW       = timer_width(CLKS_PER_BIT);

    logic [TW-1:0] tick;

    assign half_hit = (tick == TW'(HALF_BIT));
    assign full_hit = (tick == TW'(CLKS_PER_BIT - 1));

    // Free-running bit counter, wraps at the end of each bit period
    always_ff @(posedge CLK) begin
        if (CLR || restart) begin
            tick <= '0;
        end else if (full_hit) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8-bit asynchronous serial receiver (start 0, D0 first,
//               stop 1). Two-flop input synchroniser, bit-centre sampling,
//               framing-error pulse and break recovery.
//               Optional macro UART_RX_PARITY_EN adds an even-parity bit
//               and the PARITY_ERR output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 SERIAL_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 PARITY_ERR
`endif
);

    uart_state_t          state;
    uart_state_t          state_next;
    logic                 sync_meta;
    logic                 rx_s;
    logic                 restart;
    logic                 half_hit;
    logic                 full_hit;
    logic                 shift_en;
    logic                 idx_clr;
    logic                 load_data;
    logic                 set_ferr;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx;
`ifdef UART_RX_PARITY_EN
    logic                 par_cap;
    logic                 par_bit;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .CLK      (CLK),
        .CLR      (CLR),
        .restart  (restart),
        .half_hit (half_hit),
        .full_hit (full_hit)
    );

    assign BUSY = (state != IDLE);

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync_meta <= IDLE_LEVEL;
            rx_s      <= IDLE_LEVEL;
        end else begin
            sync_meta <= SERIAL_IN;
            rx_s      <= sync_meta;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        load_data  = 1'b0;
        set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Hold the timer at zero so START begins counting from 0
                restart = 1'b1;
                if (rx_s == START_LEVEL) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_hit) begin
                    restart = 1'b1;
                    if (rx_s == START_LEVEL) begin
                        state_next = DATA;
                        idx_clr    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_hit) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_hit) begin
                    par_cap    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (full_hit) begin
                    if (rx_s == STOP_LEVEL) begin
                        load_data  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        set_ferr   = 1'b1;
                        state_next = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                // Break: ignore the low line until it returns high
                restart = 1'b1;
                if (rx_s == IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit index; bits enter at the MSB so D0 ends at LSB
    always_ff @(posedge CLK) begin
        if (CLR) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // Registered outputs: byte delivery and one-cycle status pulses
    always_ff @(posedge CLK) begin
        if (CLR) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            DATA_VALID <= load_data;
            FRAME_ERR  <= set_ferr;
            if (load_data) begin
                DATA_OUT <= shift_reg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity capture and check, reported alongside DATA_VALID
    always_ff @(posedge CLK) begin
        if (CLR) begin
            par_bit    <= 1'b0;
            PARITY_ERR <= 1'b0;
        end else begin
            if (par_cap) begin
                par_bit <= rx_s;
            end
            PARITY_ERR <= load_data & ((^shift_reg) ^ par_bit);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 4 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic       SERIAL_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       FRAME_ERR;
    logic       BUSY;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
    int         perr_cnt   = 0;
    int         perr_alone = 0;
`endif

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         cyc         = 0;
    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    int         busy_cnt    = 0;
    int         last_cyc    = 0;
    int         prev_cyc    = 0;
    logic [7:0] last_data   = 8'h00;
    logic [7:0] prev_data   = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .SERIAL_IN  (SERIAL_IN),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .FRAME_ERR  (FRAME_ERR),
        .BUSY       (BUSY)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ERR (PARITY_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    // Cycle counter
    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge
    always @(negedge CLK) begin
        busy_cnt <= busy_cnt + int'(BUSY);
        if (DATA_VALID) begin
            valid_cnt <= valid_cnt + 1;
            prev_cyc  <= last_cyc;
            prev_data <= last_data;
            last_cyc  <= cyc;
            last_data <= DATA_OUT;
        end
        if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
        if (DATA_VALID && FRAME_ERR) overlap_cnt <= overlap_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (PARITY_ERR) perr_cnt <= perr_cnt + 1;
        if (PARITY_ERR && !DATA_VALID) perr_alone <= perr_alone + 1;
`endif
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        SERIAL_IN = b;
        step(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`else
        if (bad_par) $display("note: parity not built, request ignored");
`endif
        send_bit(stop);
    endtask

    int v0, f0, b0, lows;

    initial begin
        // 1: reset and idle line
        SERIAL_IN = 1'b1;
        CLR       = 1'b1;
        step(3);
        chk("rst_data", int'(DATA_OUT), 8'h00);
        chk("rst_valid", int'(DATA_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        CLR = 1'b0;
        step(50);
        chk("idle_data", int'(DATA_OUT), 8'h00);
        chk("idle_busy", int'(BUSY), 0);
        chk("idle_valid_cnt", valid_cnt, 0);
        chk("idle_ferr_cnt", ferr_cnt, 0);

        // 2: single good frame 0x0B
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h0B, 1'b1, 1'b0);
        step(3 * CPB);
        chk("b0B_valid_cnt", valid_cnt - v0, 1);
        chk("b0B_data_at_strobe", int'(last_data), 8'h0B);
        chk("b0B_data_after", int'(DATA_OUT), 8'h0B);
        chk("b0B_ferr_cnt", ferr_cnt - f0, 0);
        chk("b0B_busy", int'(BUSY), 0);

        // 3: one-cycle low glitch is a false start
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        SERIAL_IN = 1'b0;
        step(1);
        SERIAL_IN = 1'b1;
        step(20);
        chk("glitch_busy_cycles", busy_cnt - b0, CPB / 2 + 1);
        chk("glitch_valid_cnt", valid_cnt - v0, 0);
        chk("glitch_ferr_cnt", ferr_cnt - f0, 0);
        chk("glitch_data", int'(DATA_OUT), 8'h0B);
        chk("glitch_busy", int'(BUSY), 0);

        // 4: bad stop bit, long break, then recovery with 0x3C
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        SERIAL_IN = 1'b0;
        lows = 0;
        repeat (20 * CPB) begin
            step(1);
            if (!BUSY) lows++;
        end
        chk("brk_busy_low_cycles", lows, 0);
        chk("brk_ferr_cnt", ferr_cnt - f0, 1);
        chk("brk_valid_cnt", valid_cnt - v0, 0);
        chk("brk_data_held", int'(DATA_OUT), 8'h0B);
        SERIAL_IN = 1'b1;
        step(2 * CPB);
        chk("brk_busy_released", int'(BUSY), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        step(3 * CPB);
        chk("b3C_valid_cnt", valid_cnt - v0, 1);
        chk("b3C_data", int'(DATA_OUT), 8'h3C);
        chk("b3C_ferr_total", ferr_cnt - f0, 1);

        // 5: back-to-back 0x55, 0xFF with no idle gap
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        step(3 * CPB);
        chk("b2b_valid_cnt", valid_cnt - v0, 2);
        chk("b2b_first_data", int'(prev_data), 8'h55);
        chk("b2b_second_data", int'(last_data), 8'hFF);
        chk("b2b_spacing", last_cyc - prev_cyc, FRAME_BITS * CPB);

        // 6: reset during 4th data bit of 0x81, then a full 0x81
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        SERIAL_IN = 1'b0;
        step(2);
        CLR       = 1'b1;
        SERIAL_IN = 1'b1;
        step(1);
        CLR = 1'b0;
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_data", int'(DATA_OUT), 8'h00);
        step(3 * CPB);
        chk("abort_valid_cnt", valid_cnt - v0, 0);
        chk("abort_ferr_cnt", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        step(3 * CPB);
        chk("b81_valid_cnt", valid_cnt - v0, 1);
        chk("b81_data", int'(DATA_OUT), 8'h81);

`ifdef UART_RX_PARITY_EN
        chk("par_no_err_so_far", perr_cnt, 0);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        step(3 * CPB);
        chk("par_valid_cnt", valid_cnt - v0, 1);
        chk("par_err_cnt", perr_cnt, 1);
        chk("par_err_with_valid", perr_alone, 0);
        chk("par_data", int'(DATA_OUT), 8'h81);
`endif

        chk("valid_ferr_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
